// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous 256x8 memory between instruction
// fetch (if), CPU load/store (dm) and the host loader (hs). One access is in
// flight at a time; each takes IDLE -> ACCESS -> RESP. Round-robin priority
// over hs, dm, if, with a host lock for burst loads and a watchdog that breaks
// a lock the host has left idle.
module mem_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_ack,
  input  logic              hs_req,
  input  logic              hs_we,
  input  logic [ADDR_W-1:0] hs_addr,
  input  logic [DATA_W-1:0] hs_wdata,
  input  logic              hs_lock,
  output logic              hs_gnt,
  output logic              hs_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              lock_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  // Requester indices double as bit positions in the gnt/ack vectors.
  localparam logic [1:0] R_HS = 2'd0;
  localparam logic [1:0] R_DM = 2'd1;
  localparam logic [1:0] R_IF = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t            state_q;
  logic [1:0]        ptr_q;      // first requester searched in the next IDLE
  logic [1:0]        sel_q;      // winner of the access in flight
  logic              lock_q;
  logic              lock_err_q;
  logic [CNT_W-1:0]  wd_cnt_q;
  logic [2:0]        gnt_q;
  logic [2:0]        ack_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic              acc_we_q;   // in-flight access is a write
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata_q;

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == R_IF) ? R_HS : p + 2'd1;
  endfunction

  logic              lock_live, wd_fire, lock_hold, win_vld;
  logic [2:0]        elig;
  logic [1:0]        o1, o2, win;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // IDLE-cycle arbitration: lock/watchdog eligibility, then round-robin pick.
  always_comb begin
    lock_live = lock_q & hs_lock;
    // Fires on the LOCK_MAX-th idle cycle of a held lock; the freed slot is
    // arbitrated in the same cycle.
    wd_fire   = lock_live & ~hs_req & (wd_cnt_q == CNT_W'(LOCK_MAX - 1));
    lock_hold = lock_live & ~wd_fire;
    // Dropping hs_lock frees the other requesters in that same cycle.
    elig      = lock_hold ? {2'b00, hs_req} : {if_req, dm_req, hs_req};
    o1        = rr_next(ptr_q);
    o2        = rr_next(o1);
    win_vld   = |elig;
    if (elig[ptr_q])   win = ptr_q;
    else if (elig[o1]) win = o1;
    else               win = o2;
  end

  // Winner's request fields.
  always_comb begin
    w_we    = 1'b0;
    w_addr  = if_addr;
    w_wdata = '0;
    case (win)
      R_HS: begin w_we = hs_we; w_addr = hs_addr; w_wdata = hs_wdata; end
      R_DM: begin w_we = dm_we; w_addr = dm_addr; w_wdata = dm_wdata; end
      default: ;
    endcase
  end

  // Access FSM with registered handshakes, memory controls, lock and watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= R_HS;
      sel_q       <= R_HS;
      lock_q      <= 1'b0;
      lock_err_q  <= 1'b0;
      wd_cnt_q    <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      acc_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      gnt_q    <= '0;
      ack_q    <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wd_fire) lock_err_q <= 1'b1;
          if (win_vld && win == R_HS) lock_q <= hs_lock;
          else if (!lock_hold)        lock_q <= 1'b0;
          if ((win_vld && win == R_HS) || !lock_hold) wd_cnt_q <= '0;
          else if (!hs_req)                           wd_cnt_q <= wd_cnt_q + CNT_W'(1);
          if (win_vld) begin
            sel_q       <= win;
            ptr_q       <= rr_next(win);
            gnt_q       <= 3'b001 << win;
            mem_en_q    <= 1'b1;
            mem_we_q    <= w_we;
            acc_we_q    <= w_we;
            mem_addr_q  <= w_addr;
            mem_wdata_q <= w_wdata;
            state_q     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          ack_q   <= 3'b001 << sel_q;
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (!acc_we_q) rdata_q <= mem_rdata;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A reset landing on the grant or response cycle suppresses that handshake.
  assign {if_gnt, dm_gnt, hs_gnt} = gnt_q & {3{~rst}};
  assign {if_ack, dm_ack, hs_ack} = ack_q & {3{~rst}};

  // Memory read data arrives during RESP; pass it through while ack is high,
  // otherwise show the last read value.
  assign rdata     = (state_q == S_RESP && !acc_we_q && !rst) ? mem_rdata : rdata_q;
  assign lock_err  = lock_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level round-robin/memory model.
module tb_mem_port_arbiter;

  localparam int LM = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       if_req, if_gnt, if_ack;
  logic [7:0] if_addr;
  logic       dm_req, dm_we, dm_gnt, dm_ack;
  logic [7:0] dm_addr, dm_wdata;
  logic       hs_req, hs_we, hs_lock, hs_gnt, hs_ack;
  logic [7:0] hs_addr, hs_wdata;
  logic [7:0] rdata;
  logic       lock_err, mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic       bd_we;
  logic [7:0] bd_addr, bd_data;
  logic [7:0] mem [256];
  logic [7:0] shadow [256];

  int n_chk = 0;
  int n_fail = 0;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_ack(dm_ack),
    .hs_req(hs_req), .hs_we(hs_we), .hs_addr(hs_addr), .hs_wdata(hs_wdata),
    .hs_lock(hs_lock), .hs_gnt(hs_gnt), .hs_ack(hs_ack),
    .rdata(rdata), .lock_err(lock_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous 256x8 memory with a bench backdoor write port.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs;
    if_req = 0; if_addr = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    hs_req = 0; hs_we = 0; hs_addr = 0; hs_wdata = 0; hs_lock = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
    bd_we = 1; bd_addr = a; bd_data = d; tick(); bd_we = 0;
  endtask

  task automatic test_reset;
    idle_inputs(); rst = 1; tick(); tick();
    for (int p = 0; p < 2; p++) begin
      n_chk++; if ({if_gnt, dm_gnt, hs_gnt, if_ack, dm_ack, hs_ack} !== 6'b0) begin
        n_fail++; $display("FAIL reset_hs p%0d got=%b exp=0", p, {if_gnt, dm_gnt, hs_gnt, if_ack, dm_ack, hs_ack}); end
      n_chk++; if ({mem_en, mem_we, lock_err} !== 3'b0) begin
        n_fail++; $display("FAIL reset_ctl p%0d got=%b exp=000", p, {mem_en, mem_we, lock_err}); end
      n_chk++; if ({mem_addr, mem_wdata, rdata} !== 24'h0) begin
        n_fail++; $display("FAIL reset_data p%0d got=%h exp=0", p, {mem_addr, mem_wdata, rdata}); end
      rst = 0; tick();
    end
  endtask

  task automatic test_single_fetch;
    do_reset(); bd_write(8'h05, 8'hC8);
    if_req = 1; if_addr = 8'h05; tick();
    n_chk++; if ({if_gnt, dm_gnt, hs_gnt} !== 3'b100) begin
      n_fail++; $display("FAIL fetch_gnt got=%b exp=100", {if_gnt, dm_gnt, hs_gnt}); end
    n_chk++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 8'h05}) begin
      n_fail++; $display("FAIL fetch_mem got=%b/%b/%h exp=1/0/05", mem_en, mem_we, mem_addr); end
    if_req = 0; tick();
    n_chk++; if ({if_ack, if_gnt, mem_we} !== 3'b100) begin
      n_fail++; $display("FAIL fetch_ack got=%b exp=100", {if_ack, if_gnt, mem_we}); end
    n_chk++; if (rdata !== 8'hC8) begin
      n_fail++; $display("FAIL fetch_rdata got=%h exp=c8", rdata); end
    tick();
    n_chk++; if (if_ack !== 1'b0) begin
      n_fail++; $display("FAIL fetch_ack_end got=%b exp=0", if_ack); end
  endtask

  task automatic test_write_read;
    do_reset();
    dm_req = 1; dm_we = 1; dm_addr = 8'hFE; dm_wdata = 8'h02; tick();
    n_chk++; if ({dm_gnt, mem_we, mem_addr, mem_wdata} !== {2'b11, 8'hFE, 8'h02}) begin
      n_fail++; $display("FAIL wr_gnt got=%b/%b/%h/%h exp=1/1/fe/02", dm_gnt, mem_we, mem_addr, mem_wdata); end
    dm_we = 0; tick();
    n_chk++; if ({dm_ack, mem_we} !== 2'b10) begin
      n_fail++; $display("FAIL wr_ack got=%b exp=10", {dm_ack, mem_we}); end
    tick();
    n_chk++; if ({dm_gnt, dm_ack} !== 2'b00) begin
      n_fail++; $display("FAIL wr_gap got=%b exp=00", {dm_gnt, dm_ack}); end
    tick();
    n_chk++; if ({dm_gnt, mem_en, mem_we} !== 3'b110) begin
      n_fail++; $display("FAIL rd_gnt got=%b exp=110", {dm_gnt, mem_en, mem_we}); end
    dm_req = 0; tick();
    n_chk++; if ({dm_ack, rdata} !== {1'b1, 8'h02}) begin
      n_fail++; $display("FAIL rd_ack got=%b/%h exp=1/02", dm_ack, rdata); end
    n_chk++; if (mem[8'hFE] !== 8'h02) begin
      n_fail++; $display("FAIL wr_mem got=%h exp=02", mem[8'hFE]); end
    tick();
  endtask

  task automatic test_contention;
    logic [2:0] one = 3'b001;
    logic [2:0] exp;
    do_reset();
    hs_req = 1; dm_req = 1; if_req = 1;
    for (int k = 0; k < 9; k++) begin
      exp = one << (k % 3);
      tick();
      n_chk++; if ({if_gnt, dm_gnt, hs_gnt, if_ack, dm_ack, hs_ack} !== {exp, 3'b000}) begin
        n_fail++; $display("FAIL cont_gnt k%0d got=%b exp=%b000", k, {if_gnt, dm_gnt, hs_gnt, if_ack, dm_ack, hs_ack}, exp); end
      tick();
      n_chk++; if ({if_gnt, dm_gnt, hs_gnt, if_ack, dm_ack, hs_ack} !== {3'b000, exp}) begin
        n_fail++; $display("FAIL cont_ack k%0d got=%b exp=000%b", k, {if_gnt, dm_gnt, hs_gnt, if_ack, dm_ack, hs_ack}, exp); end
      if (k == 8) idle_inputs();
      tick();
      n_chk++; if ({if_ack, dm_ack, hs_ack} !== 3'b000) begin
        n_fail++; $display("FAIL cont_idle k%0d got=%b exp=000", k, {if_ack, dm_ack, hs_ack}); end
    end
  endtask

  task automatic test_lock_burst;
    logic [7:0] d;
    do_reset();
    if_req = 1; if_addr = 8'h03;
    hs_req = 1; hs_we = 1; hs_lock = 1; hs_addr = 8'h00; hs_wdata = 8'hA0;
    for (int i = 0; i < 4; i++) begin
      d = 8'hA0 + 8'(i);
      tick();
      n_chk++; if ({hs_gnt, if_gnt, mem_addr, mem_wdata} !== {2'b10, 8'(i), d}) begin
        n_fail++; $display("FAIL lock_gnt i%0d got=%b%b/%h/%h exp=10/%h/%h", i, hs_gnt, if_gnt, mem_addr, mem_wdata, 8'(i), d); end
      if (i < 3) begin hs_addr = 8'(i + 1); hs_wdata = d + 8'h01; end
      else hs_req = 0;
      tick();
      n_chk++; if ({hs_ack, if_gnt} !== 2'b10) begin
        n_fail++; $display("FAIL lock_ack i%0d got=%b exp=10", i, {hs_ack, if_gnt}); end
      tick();
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      n_chk++; if (if_gnt !== 1'b0) begin
        n_fail++; $display("FAIL lock_hold j%0d got=%b exp=0", j, if_gnt); end
    end
    hs_lock = 0; tick();
    n_chk++; if ({if_gnt, dm_gnt, hs_gnt} !== 3'b100) begin
      n_fail++; $display("FAIL lock_release got=%b exp=100", {if_gnt, dm_gnt, hs_gnt}); end
    if_req = 0; tick(); tick();
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (mem[i] !== 8'hA0 + 8'(i)) begin
        n_fail++; $display("FAIL lock_mem a%0d got=%h exp=%h", i, mem[i], 8'hA0 + 8'(i)); end
    end
  endtask

  task automatic test_watchdog;
    do_reset();
    hs_req = 1; hs_lock = 1; hs_we = 0; hs_addr = 8'h20; tick();
    n_chk++; if (hs_gnt !== 1'b1) begin
      n_fail++; $display("FAIL wd_hs_gnt got=%b exp=1", hs_gnt); end
    hs_req = 0; dm_req = 1; dm_we = 0; dm_addr = 8'h10;
    tick(); tick();   // RESP, then first locked idle cycle
    for (int i = 1; i < LM; i++) begin
      tick();
      n_chk++; if ({dm_gnt, lock_err} !== 2'b00) begin
        n_fail++; $display("FAIL wd_wait i%0d got=%b exp=00", i, {dm_gnt, lock_err}); end
    end
    tick();
    n_chk++; if ({dm_gnt, lock_err} !== 2'b11) begin
      n_fail++; $display("FAIL wd_fire got=%b exp=11", {dm_gnt, lock_err}); end
    dm_req = 0; tick();
    n_chk++; if (dm_ack !== 1'b1) begin
      n_fail++; $display("FAIL wd_dm_ack got=%b exp=1", dm_ack); end
    tick(); tick(); tick();
    n_chk++; if (lock_err !== 1'b1) begin
      n_fail++; $display("FAIL wd_sticky got=%b exp=1", lock_err); end
    hs_lock = 0; rst = 1; tick();
    n_chk++; if (lock_err !== 1'b0) begin
      n_fail++; $display("FAIL wd_clear got=%b exp=0", lock_err); end
    rst = 0; tick();
  endtask

  task automatic test_reset_mid_op;
    do_reset();
    dm_req = 1; dm_we = 0; dm_addr = 8'h10; tick();
    n_chk++; if (dm_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rmo_gnt got=%b exp=1", dm_gnt); end
    dm_req = 0; tick();
    rst = 1; #1;
    n_chk++; if (dm_ack !== 1'b0) begin
      n_fail++; $display("FAIL rmo_noack got=%b exp=0", dm_ack); end
    tick();
    n_chk++; if ({if_gnt, dm_gnt, hs_gnt, if_ack, dm_ack, hs_ack, mem_en, mem_we, lock_err} !== 9'b0) begin
      n_fail++; $display("FAIL rmo_ctl got=%b exp=0", {if_gnt, dm_gnt, hs_gnt, if_ack, dm_ack, hs_ack, mem_en, mem_we, lock_err}); end
    n_chk++; if ({mem_addr, mem_wdata, rdata} !== 24'h0) begin
      n_fail++; $display("FAIL rmo_data got=%h exp=0", {mem_addr, mem_wdata, rdata}); end
    rst = 0; hs_req = 1; dm_req = 1; if_req = 1; tick();
    n_chk++; if ({if_gnt, dm_gnt, hs_gnt} !== 3'b001) begin
      n_fail++; $display("FAIL rmo_first got=%b exp=001", {if_gnt, dm_gnt, hs_gnt}); end
    idle_inputs(); tick(); tick();
  endtask

  // Random traffic without locks; model = pending table + round robin + shadow memory.
  task automatic test_random;
    bit         pend [3];
    bit         pwe [3];
    logic [7:0] pa [3];
    logic [7:0] pd [3];
    int         age, win, last, idx;
    bit         twe;
    logic [7:0] ta, td, exp_rd, d;
    logic [2:0] one = 3'b001;
    logic [2:0] eg, ea;
    for (int a = 0; a < 256; a++) begin
      d = 8'($urandom); bd_write(8'(a), d); shadow[a] = d;
    end
    do_reset();
    for (int r = 0; r < 3; r++) begin pend[r] = 0; pwe[r] = 0; pa[r] = 0; pd[r] = 0; end
    age = -1; win = 0; last = 2; twe = 0; ta = 0; td = 0; exp_rd = 0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      tick();
      if (age >= 0) age++;
      if (age == 3) age = -1;
      eg = (age == 1) ? one << win : 3'b000;
      ea = (age == 2) ? one << win : 3'b000;
      n_chk++; if ({if_gnt, dm_gnt, hs_gnt} !== eg) begin
        n_fail++; $display("FAIL rnd_gnt c%0d got=%b exp=%b", cyc, {if_gnt, dm_gnt, hs_gnt}, eg); end
      n_chk++; if ({if_ack, dm_ack, hs_ack} !== ea) begin
        n_fail++; $display("FAIL rnd_ack c%0d got=%b exp=%b", cyc, {if_ack, dm_ack, hs_ack}, ea); end
      if (age == 1) begin
        n_chk++; if ({mem_en, mem_we, mem_addr} !== {1'b1, twe, ta} || (twe && mem_wdata !== td)) begin
          n_fail++; $display("FAIL rnd_mem c%0d got=%b%b/%h/%h exp=1%b/%h/%h", cyc, mem_en, mem_we, mem_addr, mem_wdata, twe, ta, td); end
        pend[win] = 0;
      end
      if (age == 2 && !twe) begin
        n_chk++; if (rdata !== exp_rd) begin
          n_fail++; $display("FAIL rnd_rdata c%0d got=%h exp=%h", cyc, rdata, exp_rd); end
      end
      for (int r = 0; r < 3; r++) begin
        if (!pend[r] && $urandom_range(2) == 0) begin
          pend[r] = 1; pwe[r] = (r != 2) && $urandom_range(1) == 1;
          pa[r] = 8'($urandom); pd[r] = 8'($urandom);
        end
      end
      if (age == -1) begin
        for (int k = 0; k < 3; k++) begin
          idx = (last + 1 + k) % 3;
          if (age == -1 && pend[idx]) begin
            age = 0; win = idx; last = idx;
            twe = pwe[idx]; ta = pa[idx]; td = pd[idx];
            if (twe) shadow[ta] = td; else exp_rd = shadow[ta];
          end
        end
      end
      hs_req = pend[0]; hs_we = pwe[0]; hs_addr = pa[0]; hs_wdata = pd[0];
      dm_req = pend[1]; dm_we = pwe[1]; dm_addr = pa[1]; dm_wdata = pd[1];
      if_req = pend[2]; if_addr = pa[2];
    end
    idle_inputs(); tick(); tick(); tick();
    n_chk++; if (lock_err !== 1'b0) begin
      n_fail++; $display("FAIL rnd_lock_err got=%b exp=0", lock_err); end
  endtask

  initial begin
    bd_we = 0; bd_addr = 0; bd_data = 0; rst = 1;
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_write_read();
    test_contention();
    test_lock_burst();
    test_watchdog();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous 256x8 program/data memory between three requesters:
  - instruction fetch (if)
  - CPU data path for LOAD/STORE (dm)
  - host loader/debug port (hs)
- Serialises accesses through a 3-state FSM with round-robin priority.
- Lets the host lock the memory for burst program loading, with a watchdog that breaks a stale lock.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.
- LOCK_MAX, 64, maximum consecutive IDLE cycles a held lock may sit with hs_req low before forced release.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  fetch request (read only).
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch granted (1-cycle pulse).
- if_ack  out  1  fetch complete; rdata valid.
- dm_req  in  1  data request.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_gnt  out  1  data granted.
- dm_ack  out  1  data access complete.
- hs_req  in  1  host request.
- hs_we  in  1  host write enable.
- hs_addr  in  ADDR_W  host address.
- hs_wdata  in  DATA_W  host write data.
- hs_lock  in  1  host lock request.
- hs_gnt  out  1  host granted.
- hs_ack  out  1  host access complete.
- rdata  out  DATA_W  read data, valid only while an *_ack is high for a read.
- lock_err  out  1  sticky; set when the watchdog breaks a lock.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset values:
  - All gnt/ack outputs, mem_en, mem_we and lock_err are 0.
  - mem_addr, mem_wdata and rdata are 0.
  - FSM is in IDLE, the RR pointer starts at hs, and the lock is released.
- FSM states: IDLE, ACCESS, RESP. Exactly one access is in flight; each access takes 3 cycles.
- IDLE:
  - Requests are sampled only in IDLE.
  - If any eligible req is high, pick the winner and register sel, mem_en=1, mem_we, mem_addr and mem_wdata from the winner. Then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - The winner's gnt is 1 for this cycle only. mem_en/mem_we are held for this cycle only. Go to RESP.
- RESP:
  - The winner's ack is 1 for one cycle.
  - For a read, rdata = mem_rdata. For a write, rdata holds its previous value.
  - Go to IDLE.
- Requester rules:
  - Hold req, we, addr and wdata stable from assertion until gnt.
  - Values after gnt are don't-care.
  - req still high in the IDLE cycle after ack is a new request. Back-to-back accesses from one requester are therefore allowed, one every 3 cycles.
- Round-robin:
  - Fixed base order is hs, dm, if.
  - The search starts at the requester after the last winner.
  - With all three requesting continuously, the grant order is hs, dm, if, hs, ...
- Lock:
  - The lock is taken when hs wins in IDLE with hs_lock=1.
  - While locked, only hs is eligible; if/dm requests wait and are not dropped.
  - The lock is released in IDLE when hs_lock=0.
- Lock watchdog:
  - A counter increments on each IDLE cycle with the lock held and hs_req=0, and clears on any hs grant.
  - When the count reaches LOCK_MAX, the lock is forcibly released and lock_err is set. Arbitration resumes the same cycle.
  - lock_err clears only on rst.
- The address and data widths pass straight through; no arithmetic is performed on addresses.
- Reset asserted mid-access:
  - No ack is issued for the in-flight access.
  - A write already presented to memory in ACCESS is not undone.
  - All requesters must reissue.
- A simultaneous request and release: a dm_req arriving in the same IDLE cycle that hs_lock drops is eligible that cycle.

Test Plan:
- Single fetch: if_req=1, if_addr=8'h05, mem[5]=8'hC8 -> if_gnt at cycle t+1, if_ack at t+2 with rdata=8'hC8, mem_we=0 throughout.
- Data write then read: dm write addr 8'hFE, data 8'h02, followed by dm read 8'hFE -> mem_we=1 in the first ACCESS only, second dm_ack shows rdata=8'h02; the accesses are 3 cycles apart.
- Contention: all three reqs held high for 9 accesses from reset -> grant order hs, dm, if repeated 3 times; no ack overlaps another.
- Lock burst: hs_lock=1 with hs writes to 8'h00..8'h03 while if_req=1 -> if_gnt stays 0 until hs_lock drops; the first grant after release is if.
- Watchdog: lock taken, then hs_req=0 with hs_lock=1 for LOCK_MAX IDLE cycles while dm_req=1 -> lock_err rises, dm_gnt is granted in the next ACCESS, and lock_err stays 1 until rst.
- Reset mid-op: rst pulsed during RESP of a dm read -> no dm_ack, outputs return to reset values, and the next grant with all requesting goes to hs.
